// File: rtl/io_fetch_if.sv
// Command, request, response and output-stream signals of the fetch unit.
// slave = the fetch unit, master = command source / memory / consumer.
interface io_fetch_if #(
   parameter int IO_DATA_WIDTH = 32,
   parameter int IO_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH     = 16
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [IO_ADDR_WIDTH-1:0] cmd_base_addr;
   logic [LEN_WIDTH-1:0]     cmd_len;
   logic                     req_valid;
   logic                     req_ready;
   logic [IO_ADDR_WIDTH-1:0] data_req_addr;
   logic                     rsp_valid;
   logic [IO_DATA_WIDTH-1:0] data_in;
   logic                     out_valid;
   logic                     out_ready;
   logic [IO_DATA_WIDTH-1:0] out_data;
   logic                     busy;
   logic                     done;

   modport slave (
      input  cmd_valid, cmd_base_addr, cmd_len,
      input  req_ready, rsp_valid, data_in, out_ready,
      output cmd_ready, req_valid, data_req_addr,
      output out_valid, out_data, busy, done
   );

   modport master (
      output cmd_valid, cmd_base_addr, cmd_len,
      output req_ready, rsp_valid, data_in, out_ready,
      input  cmd_ready, req_valid, data_req_addr,
      input  out_valid, out_data, busy, done
   );
endinterface

// File: rtl/io_fetch_unit.sv
// Fetches cmd_len consecutive words into a circular buffer with flow control.
// Define IO_FETCH_STALL_CNT_EN to add the stall_cycles counter output.
module io_fetch_unit #(
   parameter int IO_DATA_WIDTH     = 32,
   parameter int IO_ADDR_WIDTH     = 32,
   parameter int DATA_BUFFER_DEPTH = 16,
   parameter int LEN_WIDTH         = 16
) (
   input  logic        clk,
   input  logic        rstn,
   io_fetch_if.slave   bus
`ifdef IO_FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int PW = $clog2(DATA_BUFFER_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DATA_BUFFER_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_e;

   state_e                   state_q;
   logic [IO_ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]     rem_q;
   logic                     cmd_ready_q;
   logic                     busy_q;
   logic                     done_q;

   logic [CW-1:0]            usage_q, usage_d;
   logic [CW-1:0]            outst_q, outst_d;
   logic [PW-1:0]            wptr_q, rptr_q;
   logic [IO_DATA_WIDTH-1:0] mem_q [DATA_BUFFER_DEPTH];

   logic cmd_fire;
   logic room;
   logic req_valid;
   logic req_fire;
   logic rsp_fire;
   logic out_valid;
   logic pop;

   assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
   // Reserve a slot for every in-flight request so responses never overflow.
   assign room      = ({1'b0, usage_q} + {1'b0, outst_q}) < DEPTH_W;
   assign req_valid = (state_q == FETCH) && (rem_q != '0) && room;
   assign req_fire  = req_valid && bus.req_ready;
   assign rsp_fire  = bus.rsp_valid && (outst_q != '0);
   assign out_valid = (usage_q != '0);
   assign pop       = out_valid && bus.out_ready;

   assign usage_d = usage_q + CW'(rsp_fire) - CW'(pop);
   assign outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.req_valid     = req_valid;
   assign bus.data_req_addr = addr_q;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = out_valid ? mem_q[rptr_q] : '0;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  addr_q <= bus.cmd_base_addr;
                  rem_q  <= bus.cmd_len;
                  if (bus.cmd_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q     <= FETCH;
                     cmd_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (req_fire) begin
                  addr_q <= addr_q + IO_ADDR_WIDTH'(1);
                  rem_q  <= rem_q - LEN_WIDTH'(1);
                  if (rem_q == LEN_WIDTH'(1)) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Looks at next-cycle counts so a final pop ends the command now.
               if (outst_d == '0 && usage_d == '0) begin
                  state_q     <= IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         usage_q <= '0;
         outst_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         usage_q <= usage_d;
         outst_q <= outst_d;
         if (rsp_fire) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_fire) begin
         mem_q[wptr_q] <= bus.data_in;
      end
   end

`ifdef IO_FETCH_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= '0;
      end else if (cmd_fire) begin
         stall_q <= '0;
      end else if (state_q == FETCH && rem_q != '0 &&
                   !req_valid && stall_q != '1) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/io_fetch_unit.md
IO_FETCH_UNIT -- requirements
Module: io_fetch_unit

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 32: width of one fetched word.
REQ-002 SHALL have parameter IO_ADDR_WIDTH, default 32: width of the word address.
REQ-003 SHALL have parameter DATA_BUFFER_DEPTH, default 16: entries in the circular buffer; power of two, >=2.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of the command length.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_base_addr  in  IO_ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  number of words to fetch.
- req_valid  out  1  read request offered.
- req_ready  in  1  request accepted.
- data_req_addr  out  IO_ADDR_WIDTH  request word address.
- rsp_valid  in  1  response word present, in request order.
- data_in  in  IO_DATA_WIDTH  response word.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer pops the head.
- out_data  out  IO_DATA_WIDTH  buffer head word.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pulse at command completion.

Function
REQ-006 SHALL implement the states IDLE, FETCH and DRAIN.
REQ-007 SHALL drive cmd_ready high only in IDLE.
REQ-008 On cmd_valid&&cmd_ready, SHALL latch addr=cmd_base_addr and remaining=cmd_len, then enter FETCH (cmd_len!=0) or stay IDLE and pulse done the next cycle (cmd_len==0).
REQ-009 SHALL drive req_valid in FETCH when remaining!=0 and (usage+outstanding)<DATA_BUFFER_DEPTH; data_req_addr=addr.
REQ-010 On each req_valid&&req_ready, SHALL:
- increment addr by 1 (modulo 2^IO_ADDR_WIDTH);
- decrement remaining;
- increment outstanding.
REQ-011 SHALL keep data_req_addr stable while req_valid is high and req_ready is low.
REQ-012 On rsp_valid with outstanding!=0, SHALL write data_in at the write pointer, advance it (wrap at DATA_BUFFER_DEPTH), increment usage and decrement outstanding.
REQ-013 SHALL ignore rsp_valid when outstanding==0: no write, no counter change.
REQ-014 SHALL drive out_valid=(usage!=0) and out_data=entry at the read pointer.
REQ-015 On out_valid&&out_ready, SHALL advance the read pointer (wrap) and decrement usage.
REQ-016 A push and a pop in the same cycle SHALL leave usage unchanged.
REQ-017 A word written at edge N SHALL be visible on out_valid/out_data after edge N (one-cycle latency).
REQ-018 usage and outstanding SHALL each be $clog2(DATA_BUFFER_DEPTH)+1 bits wide; their sum SHALL never exceed DATA_BUFFER_DEPTH, so the buffer cannot overflow.
REQ-019 SHALL move FETCH->DRAIN when the last request is accepted.
REQ-020 SHALL move DRAIN->IDLE when outstanding==0 and usage==0 (including any pop that same cycle), pulsing done for exactly one cycle on that transition.
REQ-021 busy SHALL be high in FETCH and DRAIN.

Reset
REQ-022 While rstn is low, SHALL hold the following, asynchronously:
- state IDLE;
- pointers, usage, outstanding, remaining and addr at 0;
- req_valid, out_valid, done and busy at 0;
- cmd_ready at 1;
- data_req_addr and out_data at 0.
REQ-023 Reset asserted mid-command SHALL discard all buffered and outstanding data; responses arriving after reset are ignored per REQ-013.
REQ-024 Buffer storage contents need not be reset.

Configuration
REQ-025 With macro IO_FETCH_STALL_CNT_EN defined, SHALL add output stall_cycles (32 bits, reset 0). It counts cycles where req_valid is low in FETCH with remaining!=0, saturates at all-ones, and clears on command acceptance.
REQ-026 Without IO_FETCH_STALL_CNT_EN, stall_cycles and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-027 Fetch: cmd base=0x100, len=4, req_ready=1, 2-cycle response latency, out_ready=1 -> requests at 0x100..0x103 on consecutive cycles; out_data sequence matches; done pulses once; busy then falls.
REQ-028 Back-pressure: depth 16, len=40, out_ready=0 -> exactly 16 requests issued, then req_valid=0; after out_ready=1, remaining 24 requests complete in order.
REQ-029 Zero length: cmd len=0 -> no req_valid; done high exactly one cycle; cmd_ready stays 1.
REQ-030 Address wrap: IO_ADDR_WIDTH=8, base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-031 Reset mid-command: len=10, rstn low after 5 requests -> all outputs take reset values; stray rsp_valid ignored; a new cmd len=2 completes correctly.
REQ-032 Stall counter: with IO_FETCH_STALL_CNT_EN, req_ready=0 for 7 cycles during FETCH -> stall_cycles=0; buffer-full stall of 5 cycles -> stall_cycles=5.
